// File: rtl/mod_seq_unit.sv
// -----------------------------------------------------------------------------
// mod_seq_unit
//
// Sequential unsigned modulo unit (A mod B) using restoring division, one
// quotient bit per clock. Its result feeds the op_mod input of the ALU's
// 1-bit 8:1 result mux, one result bit per mux slice.
//
// Ports
//   clk       system clock, all state updates on the rising edge
//   rst_n     synchronous active-low reset
//   start     operation request, accepted only while idle
//   a, b      dividend / divisor, captured on an accepted start
//   result    a mod b (a when b == 0), updated only on entry to DONE
//   busy      high while iterating (CALC)
//   done      one-cycle pulse, result valid
//   div_zero  set with result when the captured divisor was zero
// -----------------------------------------------------------------------------
module mod_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               div_zero_q, div_zero_d;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, then subtract the divisor if it fits. Everything is kept
    // WIDTH+1 bits wide so the compare never wraps.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_sub;
    logic               rem_ge;
    logic [WIDTH:0]     rem_step;

    always_comb begin
        rem_shift = {rem_q[WIDTH-1:0], dividend_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, divisor_q};
        rem_ge    = (rem_shift >= {1'b0, divisor_q});
        rem_step  = rem_ge ? rem_sub : rem_shift;
    end

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dividend_d = a;
                    divisor_d  = b;
                    rem_d      = '0;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    if (b == '0) begin
                        // Nothing to iterate: the remainder of x mod 0 is
                        // defined as x, flagged by div_zero.
                        result_d   = a;
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        state_d    = S_CALC;
                    end
                end
            end
            S_CALC: begin
                rem_d      = rem_step;
                dividend_d = {dividend_q[WIDTH-2:0], 1'b0};
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // Last iteration: publish the final remainder only now so
                    // the mux never observes a partial value.
                    result_d = rem_step[WIDTH-1:0];
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Status outputs are pure decodes of the registered state, so busy and
    // done are mutually exclusive by construction.
    assign busy     = (state_q == S_CALC);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mod_seq_unit.sv
`timescale 1ns/1ps
module tb_mod_seq_unit;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             div_zero;

    int checks = 0;
    int errors = 0;

    mod_seq_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .result   (result),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; everything after this is driven/sampled 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain unsigned modulo, with x mod 0 defined as x.
    function automatic logic [WIDTH-1:0] ref_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (y == '0) return x;
        return x % y;
    endfunction

    // Expected edges from presenting start until done is visible.
    function automatic int ref_lat(input logic [WIDTH-1:0] y);
        return (y == '0) ? 1 : WIDTH + 1;
    endfunction

    // Presents one request from idle and waits (bounded) for done.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          output logic [WIDTH-1:0] res, output logic dz, output int lat,
                          output logic busy1, output logic dz1, output logic [WIDTH-1:0] res1);
        start = 1'b1;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        busy1 = busy;
        dz1   = div_zero;
        res1  = result;
        lat   = 1;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        res = result;
        dz  = div_zero;
        $display("op a=%08h b=%08h -> result=%08h div_zero=%0b latency=%0d", av, bv, res, dz, lat);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) tick();
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: result=%h busy=%b done=%b div_zero=%b, required 0/0/0/0",
                     result, busy, done, div_zero);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: result=%h busy=%b done=%b, required 0/0/0", result, busy, done);
        end
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] res, res1;
        logic dz, busy1, dz1;
        int lat;
        run_op(32'd17, 32'd5, res, dz, lat, busy1, dz1, res1);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy=%b, required 1", busy1);
        end
        checks++;
        if (res1 !== '0) begin
            errors++;
            $display("FAIL basic_result_during_calc: result=%h, required 0", res1);
        end
        checks++;
        if (lat !== ref_lat(32'd5)) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required %0d", lat, ref_lat(32'd5));
        end
        checks++;
        if (res !== ref_mod(32'd17, 32'd5) || dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: result=%h dz=%b, required %h dz=0", res, dz, ref_mod(32'd17, 32'd5));
        end
        // One cycle later (already idle) done must be gone; result must hold.
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b one cycle after, required 0", done);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (result !== 32'd2 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_hold[%0d]: result=%h busy=%b done=%b, required 2/0/0", i, result, busy, done);
            end
            tick();
        end
    endtask

    task automatic test_boundaries();
        logic [WIDTH-1:0] av [5] = '{32'hFFFF_FFFF, 32'd3, 32'd9, 32'd0, 32'h8000_0000};
        logic [WIDTH-1:0] bv [5] = '{32'd16,       32'd7, 32'd9, 32'd5, 32'hFFFF_FFFF};
        logic [WIDTH-1:0] ex [5] = '{32'd15,       32'd3, 32'd0, 32'd0, 32'h8000_0000};
        logic [WIDTH-1:0] res, res1;
        logic dz, busy1, dz1;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(av[i], bv[i], res, dz, lat, busy1, dz1, res1);
            checks++;
            if (res !== ex[i] || res !== ref_mod(av[i], bv[i]) || dz !== 1'b0) begin
                errors++;
                $display("FAIL boundary[%0d]: result=%h dz=%b, required %h dz=0", i, res, dz, ex[i]);
            end
            checks++;
            if (lat !== WIDTH + 1) begin
                errors++;
                $display("FAIL boundary_latency[%0d]: got %0d, required %0d", i, lat, WIDTH + 1);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [WIDTH-1:0] res, res1;
        logic dz, busy1, dz1;
        int lat;
        run_op(32'h1234, 32'd0, res, dz, lat, busy1, dz1, res1);
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL divzero_busy: busy=%b, required 0", busy1);
        end
        checks++;
        if (lat !== ref_lat(32'd0)) begin
            errors++;
            $display("FAIL divzero_latency: got %0d, required %0d", lat, ref_lat(32'd0));
        end
        checks++;
        if (res !== 32'h1234 || dz !== 1'b1) begin
            errors++;
            $display("FAIL divzero_result: result=%h dz=%b, required 00001234 dz=1", res, dz);
        end
        checks++;
        if (div_zero !== 1'b1 || result !== 32'h1234) begin
            errors++;
            $display("FAIL divzero_hold: result=%h dz=%b, required 00001234 dz=1", result, div_zero);
        end
        run_op(32'd10, 32'd3, res, dz, lat, busy1, dz1, res1);
        checks++;
        if (dz1 !== 1'b0 || res1 !== 32'h1234) begin
            errors++;
            $display("FAIL divzero_clear_at_accept: dz=%b result=%h, required dz=0 result=00001234", dz1, res1);
        end
        checks++;
        if (res !== 32'd1 || dz !== 1'b0) begin
            errors++;
            $display("FAIL divzero_next_op: result=%h dz=%b, required 1 dz=0", res, dz);
        end
    endtask

    task automatic test_handshake();
        int lat;
        int extra_done;
        start = 1'b1;
        a     = 32'd100;
        b     = 32'd7;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 100) begin
            // Intrusive request while busy, with operands churning every cycle.
            start = (lat >= 4 && lat <= 9);
            a     = (lat == 4) ? 32'd5 : $urandom;
            b     = (lat == 4) ? 32'd2 : $urandom;
            tick();
            lat++;
        end
        start = 1'b0;
        $display("op a=%08h b=%08h -> result=%08h div_zero=%0b latency=%0d (with ignored start)",
                 32'd100, 32'd7, result, div_zero, lat);
        checks++;
        if (lat !== WIDTH + 1) begin
            errors++;
            $display("FAIL handshake_latency: got %0d, required %0d", lat, WIDTH + 1);
        end
        checks++;
        if (result !== ref_mod(32'd100, 32'd7)) begin
            errors++;
            $display("FAIL handshake_result: result=%h, required %h", result, ref_mod(32'd100, 32'd7));
        end
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) extra_done++;
        end
        checks++;
        if (extra_done !== 0) begin
            errors++;
            $display("FAIL handshake_second_request: %0d busy/done cycles seen, required 0", extra_done);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [WIDTH-1:0] res, res1;
        logic dz, busy1, dz1;
        int lat;
        int stray;
        start = 1'b1;
        a     = 32'd1000;
        b     = 32'd9;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        $display("op a=%08h b=%08h -> aborted by reset", 32'd1000, 32'd9);
        checks++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: result=%h busy=%b done=%b dz=%b, required 0/0/0/0",
                     result, busy, done, div_zero);
        end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: %0d busy/done cycles after abort, required 0", stray);
        end
        run_op(32'd1000, 32'd9, res, dz, lat, busy1, dz1, res1);
        checks++;
        if (res !== ref_mod(32'd1000, 32'd9) || lat !== WIDTH + 1) begin
            errors++;
            $display("FAIL midreset_fresh_op: result=%h latency=%0d, required %h latency=%0d",
                     res, lat, ref_mod(32'd1000, 32'd9), WIDTH + 1);
        end
    endtask

    function automatic logic [WIDTH-1:0] gen_a();
        int r = $urandom_range(0, 7);
        if (r == 0) return '1;
        if (r == 1) return '0;
        return $urandom;
    endfunction

    function automatic logic [WIDTH-1:0] gen_b();
        int r = $urandom_range(0, 7);
        if (r == 0) return '0;
        if (r == 1) return 32'd1;
        if (r == 2) return WIDTH'($urandom_range(1, 255));
        if (r == 3) return '1;
        return $urandom;
    endfunction

    task automatic test_back_to_back();
        logic [WIDTH-1:0] cur_a, cur_b;
        int cyc, last_done, n, overlap, spacing;
        cur_a = gen_a();
        cur_b = gen_b();
        start = 1'b1;
        a     = cur_a;
        b     = cur_b;
        cyc = 0;
        last_done = 0;
        n = 0;
        overlap = 0;
        while (n < 200 && cyc < 20000) begin
            tick();
            cyc++;
            if (busy && done) overlap++;
            if (done) begin
                $display("op a=%08h b=%08h -> result=%08h div_zero=%0b", cur_a, cur_b, result, div_zero);
                checks++;
                if (result !== ref_mod(cur_a, cur_b) || div_zero !== (cur_b == '0)) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: a=%h b=%h result=%h dz=%b, required %h dz=%b",
                             n, cur_a, cur_b, result, div_zero, ref_mod(cur_a, cur_b), (cur_b == '0));
                end
                if (n > 0) begin
                    // With start held, each op is accepted one idle cycle after
                    // the previous DONE, so spacing is the op's latency + 1.
                    spacing = ref_lat(cur_b) + 1;
                    checks++;
                    if (cyc - last_done !== spacing) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles, required %0d", n, cyc - last_done, spacing);
                    end
                end
                last_done = cyc;
                n++;
                cur_a = gen_a();
                cur_b = gen_b();
                a = cur_a;
                b = cur_b;
            end
        end
        start = 1'b0;
        checks++;
        if (n !== 200) begin
            errors++;
            $display("FAIL b2b_timeout: completed %0d operations, required 200", n);
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL b2b_busy_done_overlap: %0d cycles, required 0", overlap);
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_handshake();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
